// File: rtl/line_buffer_pkg.sv
// Shared types and constants for the line buffer controller.
package line_buffer_pkg;

    typedef enum logic [1:0] {
        S_FILL,
        S_READ,
        S_FLUSH
    } state_t;

    localparam int NUM_LINE_BUFS = 4;

    typedef logic [1:0] buf_idx_t;

    // Sliced to the pixel width at the point of use.
    localparam logic [63:0] ZERO_PIXEL = '0;

endpackage

// File: rtl/line_ram.sv
// One image line of storage: single write port, single registered read port.
module line_ram #(
    parameter int WIDTH     = 8,
    parameter int COLS      = 512,
    parameter int ADDR_BITS = 9
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem [COLS];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Four rotating line RAMs replaying each raster row as a 3-row column stream.
// Optional output backpressure port enabled by defining LINEBUF_OUT_READY_EN.
module line_buffer_ctrl
    import line_buffer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ROWS      = 512,
    parameter int COLS      = 512,
    parameter int LINE_BITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pixel_in,
    input  logic             pixel_in_valid,
`ifdef LINEBUF_OUT_READY_EN
    input  logic             data_out_ready,
`endif
    output logic             pixel_in_ready,
    output logic [WIDTH-1:0] data_out_0,
    output logic [WIDTH-1:0] data_out_1,
    output logic [WIDTH-1:0] data_out_2,
    output logic             data_out_valid,
    output logic             line_done,
    output logic             frame_done
);

    localparam int ADDR_BITS = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [LINE_BITS-1:0] LAST_COL = LINE_BITS'(COLS - 1);
    localparam logic [LINE_BITS-1:0] LAST_ROW = LINE_BITS'(ROWS - 1);

    state_t               state;
    buf_idx_t             wr_buf, rd_buf;
    logic [LINE_BITS-1:0] wr_col, wr_row, rd_col, rd_row;
    logic [2:0]           fill_cnt;
    logic                 run_q, frame_pending;
    logic                 accept, line_complete, line_retire;
    logic                 advance, rd_issue, rows_ready;
    buf_idx_t             top_sel, ctr_sel, bot_sel;
    logic                 zero_top, zero_bot;
    logic [WIDTH-1:0]     ram_q [NUM_LINE_BUFS];

`ifdef LINEBUF_OUT_READY_EN
    assign advance = !data_out_valid || data_out_ready;
`else
    assign advance = 1'b1;
`endif

    // A finished frame blocks row 0 of the next one until its flush has run.
    assign pixel_in_ready = run_q && (fill_cnt < 3'd4) && !(wr_row == '0 && frame_pending);
    assign accept         = pixel_in_valid && pixel_in_ready;
    assign line_complete  = accept && (wr_col == LAST_COL);
    assign rd_issue       = (state == S_READ) && advance;
    assign line_retire    = rd_issue && (rd_col == LAST_COL) && (rd_row != '0) && (rd_row != LAST_ROW);

    always_comb begin
        rows_ready = 1'b0;
        if (rd_row == LAST_ROW)  rows_ready = 1'b1;
        else if (rd_row == '0)   rows_ready = (fill_cnt >= 3'd2);
        else                     rows_ready = (fill_cnt >= 3'd3);
    end

    for (genvar i = 0; i < NUM_LINE_BUFS; i++) begin : g_ram
        line_ram #(
            .WIDTH    (WIDTH),
            .COLS     (COLS),
            .ADDR_BITS(ADDR_BITS)
        ) u_ram (
            .clk    (clk),
            .wr_en  (accept && (wr_buf == buf_idx_t'(i))),
            .wr_addr(wr_col[ADDR_BITS-1:0]),
            .wr_data(pixel_in),
            .rd_en  (rd_issue),
            .rd_addr(rd_col[ADDR_BITS-1:0]),
            .rd_data(ram_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_buf        <= '0;
            wr_col        <= '0;
            wr_row        <= '0;
            fill_cnt      <= '0;
            run_q         <= 1'b0;
            frame_pending <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (accept) begin
                if (wr_col == LAST_COL) begin
                    wr_col <= '0;
                    wr_buf <= wr_buf + 1'b1;
                    wr_row <= (wr_row == LAST_ROW) ? '0 : wr_row + 1'b1;
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
            end
            if (state == S_FLUSH)                    fill_cnt <= {2'b00, line_complete};
            else if (line_complete && !line_retire)  fill_cnt <= fill_cnt + 3'd1;
            else if (!line_complete && line_retire)  fill_cnt <= fill_cnt - 3'd1;
            if (state == S_FLUSH)                                frame_pending <= 1'b0;
            else if (line_complete && (wr_row == LAST_ROW))      frame_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_FILL;
            rd_buf         <= '0;
            rd_col         <= '0;
            rd_row         <= '0;
            data_out_valid <= 1'b0;
            line_done      <= 1'b0;
            frame_done     <= 1'b0;
            top_sel        <= '0;
            ctr_sel        <= '0;
            bot_sel        <= '0;
            zero_top       <= 1'b0;
            zero_bot       <= 1'b0;
        end else begin
            // Output-side registers move in lockstep with the RAM read register.
            if (advance) begin
                data_out_valid <= rd_issue;
                line_done      <= rd_issue && (rd_col == LAST_COL);
                frame_done     <= rd_issue && (rd_col == LAST_COL) && (rd_row == LAST_ROW);
                top_sel        <= rd_buf - 1'b1;
                ctr_sel        <= rd_buf;
                bot_sel        <= rd_buf + 1'b1;
                zero_top       <= (rd_row == '0);
                zero_bot       <= (rd_row == LAST_ROW);
            end
            case (state)
                S_FILL: begin
                    if (rows_ready) state <= S_READ;
                end
                S_READ: begin
                    if (advance) begin
                        if (rd_col == LAST_COL) begin
                            rd_col <= '0;
                            if (rd_row == LAST_ROW) begin
                                state <= S_FLUSH;
                            end else begin
                                rd_buf <= rd_buf + 1'b1;
                                rd_row <= rd_row + 1'b1;
                                state  <= S_FILL;
                            end
                        end else begin
                            rd_col <= rd_col + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    rd_row <= '0;
                    rd_buf <= wr_buf;
                    state  <= S_FILL;
                end
                default: state <= S_FILL;
            endcase
        end
    end

    assign data_out_2 = (data_out_valid && !zero_top) ? ram_q[top_sel] : ZERO_PIXEL[WIDTH-1:0];
    assign data_out_1 = data_out_valid ? ram_q[ctr_sel] : ZERO_PIXEL[WIDTH-1:0];
    assign data_out_0 = (data_out_valid && !zero_bot) ? ram_q[bot_sel] : ZERO_PIXEL[WIDTH-1:0];

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl on a 4x4 frame with pixel = 16*row+col.
`timescale 1ns/1ps
module tb_line_buffer_ctrl;

    localparam int WIDTH     = 8;
    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int LINE_BITS = 10;
    localparam int NPIX      = ROWS * COLS;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] pixel_in = '0;
    logic             pixel_in_valid = 1'b0;
    logic             pixel_in_ready;
    logic [WIDTH-1:0] data_out_0, data_out_1, data_out_2;
    logic             data_out_valid, line_done, frame_done;
    logic             out_ready = 1'b1;

    int errors = 0;
    int checks = 0;
    int beat_idx = 0;
    int frames_seen = 0;
    int pix_sent = 0;
    int pix_base = 0;
    int m_r, m_c;
    bit saw_ready_low = 1'b0;

    always #5 clk = ~clk;

    line_buffer_ctrl #(
        .WIDTH    (WIDTH),
        .ROWS     (ROWS),
        .COLS     (COLS),
        .LINE_BITS(LINE_BITS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pixel_in      (pixel_in),
        .pixel_in_valid(pixel_in_valid),
`ifdef LINEBUF_OUT_READY_EN
        .data_out_ready(out_ready),
`endif
        .pixel_in_ready(pixel_in_ready),
        .data_out_0    (data_out_0),
        .data_out_1    (data_out_1),
        .data_out_2    (data_out_2),
        .data_out_valid(data_out_valid),
        .line_done     (line_done),
        .frame_done    (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_pix(input int r, input int c);
        if (r < 0 || r >= ROWS) return 32'd0;
        return 32'(16 * r + c);
    endfunction

    // Column-beat scoreboard: index advances only when the beat is consumed.
    always @(negedge clk) begin
        if (!reset) begin
            beat_idx = 0;
        end else begin
            if (!pixel_in_ready) saw_ready_low = 1'b1;
            if (data_out_valid) begin
                m_r = beat_idx / COLS;
                m_c = beat_idx % COLS;
                if (beat_idx == 0) check("first_beat_lines", 32'(pix_sent - pix_base >= 2 * COLS), 32'd1);
                check("d2_top",     32'(data_out_2), exp_pix(m_r - 1, m_c));
                check("d1_centre",  32'(data_out_1), exp_pix(m_r, m_c));
                check("d0_bottom",  32'(data_out_0), exp_pix(m_r + 1, m_c));
                check("line_done",  32'(line_done),  32'(m_c == COLS - 1));
                check("frame_done", 32'(frame_done), 32'(beat_idx == NPIX - 1));
                if (out_ready) begin
                    if (beat_idx == NPIX - 1) begin
                        beat_idx = 0;
                        frames_seen++;
                        pix_base += NPIX;
                    end else begin
                        beat_idx++;
                    end
                end
            end
        end
    end

    task automatic send_pixel(input logic [WIDTH-1:0] p);
        int t = 0;
        pixel_in = p;
        pixel_in_valid = 1'b1;
        while (!pixel_in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("ready_timeout", 32'(t), 32'd0);
        @(negedge clk);
        pix_sent++;
        pixel_in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input int npix);
        for (int i = 0; i < npix; i++) begin
            send_pixel(WIDTH'(16 * (i / COLS) + (i % COLS)));
            if (gaps) @(negedge clk);
        end
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (frames_seen < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("frames_seen", 32'(frames_seen), 32'(n));
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid",      32'(data_out_valid), 32'd0);
        check("rst_d0",         32'(data_out_0),     32'd0);
        check("rst_d1",         32'(data_out_1),     32'd0);
        check("rst_d2",         32'(data_out_2),     32'd0);
        check("rst_line_done",  32'(line_done),      32'd0);
        check("rst_frame_done", 32'(frame_done),     32'd0);
        check("rst_ready",      32'(pixel_in_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(pixel_in_ready), 32'd1);
        check("post_rst_valid", 32'(data_out_valid), 32'd0);

        // Two continuous frames back to back.
        send_frame(1'b0, NPIX);
        send_frame(1'b0, NPIX);
        wait_frames(2);
        check("ready_backpressure", 32'(saw_ready_low), 32'd1);

        // Gapped input, optionally with a 3-cycle output stall mid-line.
`ifdef LINEBUF_OUT_READY_EN
        fork
            begin
                repeat (30) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
`endif
        send_frame(1'b1, NPIX);
        wait_frames(3);

        // Reset during row 2, then a fresh frame.
        send_frame(1'b0, 2 * COLS + 2);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_valid", 32'(data_out_valid), 32'd0);
        check("midrst_ready", 32'(pixel_in_ready), 32'd0);
        pix_base = pix_sent;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_post_valid", 32'(data_out_valid), 32'd0);
        check("midrst_post_ready", 32'(pixel_in_ready), 32'd1);
        send_frame(1'b0, NPIX);
        wait_frames(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Upstream neighbour of the 3x3 window stage. Accepts a raster pixel stream one pixel per beat.
- Stores lines in 4 rotating line RAMs and replays each image row as a 3-row column stream on data_out_0/1/2.
- data_out_2 is the top row (r-1), data_out_1 is the centre row (r), data_out_0 is the bottom row (r+1).
- Rows outside the image are driven as zero, so exactly ROWS x COLS column beats are emitted per frame.

Parameters:
- WIDTH, 8, pixel bit width
- ROWS, 512, image height in lines
- COLS, 512, image width in pixels
- LINE_BITS, 10, width of row and column counters; must satisfy 2^LINE_BITS > max(ROWS, COLS)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-low (reset==0 resets on the clock edge)
- pixel_in  in  WIDTH  incoming raster pixel
- pixel_in_valid  in  1  pixel_in is valid this cycle
- pixel_in_ready  out  1  block can accept a pixel; a write occurs when valid&&ready
- data_out_0  out  WIDTH  bottom-row pixel (row r+1)
- data_out_1  out  WIDTH  centre-row pixel (row r)
- data_out_2  out  WIDTH  top-row pixel (row r-1)
- data_out_valid  out  1  column beat valid
- line_done  out  1  1-cycle pulse with the last beat (col COLS-1) of each read line
- frame_done  out  1  1-cycle pulse with the last beat of row ROWS-1

Behaviour:
- Reset values:
  - all outputs 0; pixel_in_ready 0 during reset, 1 on the first cycle after reset.
  - wr_buf=0, wr_col=0, wr_row=0, rd_buf=0, rd_col=0, rd_row=0, fill_cnt=0, state=S_FILL.
- Write side:
  - On accept, write pixel_in to line RAM wr_buf at wr_col, then increment wr_col.
  - At COLS-1: wr_col wraps to 0, wr_buf advances mod 4, fill_cnt increments, and wr_row increments.
  - wr_row wraps at ROWS-1 to 0.
  - pixel_in_ready = (fill_cnt < 4) && !(wr_row==0 && frame still being read out). Frame N+1 may not begin until frame_done of frame N has issued.
- fill_cnt (0..4) counts completed lines held.
  - A line retire and a line completion in the same cycle leave fill_cnt unchanged.
  - fill_cnt never exceeds 4 and never underflows.
- FSM S_FILL -> S_READ -> S_FILL, plus S_FLUSH:
  - S_FILL: wait until the rows needed for centre row rd_row are present.
    - rd_row=0 needs 2 lines.
    - 0<rd_row<ROWS-1 needs row rd_row+1 complete.
    - rd_row=ROWS-1 needs no new line, so go straight to S_READ.
    - Then go to S_READ.
  - S_READ: issue one RAM read per cycle, rd_col 0..COLS-1.
    - At rd_col=COLS-1: rd_col returns to 0.
    - If rd_row=ROWS-1, go to S_FLUSH.
    - Otherwise retire row rd_row-1 (none retired when rd_row=0), advance rd_buf, increment rd_row, and go to S_FILL.
  - S_FLUSH: release all remaining lines (fill_cnt := 0; concurrent write completion counted after clear), reset rd_row=0, rd_buf=wr_buf base of next frame, then go to S_FILL.
- Latency:
  - Line RAM read is registered. data_out_* and data_out_valid appear 1 cycle after the read address is issued.
  - line_done and frame_done are aligned to that same output beat.
- Zero insertion is applied on the registered output:
  - rd_row=0: data_out_2 = 0.
  - rd_row=ROWS-1: data_out_0 = 0.
- Reset mid-frame discards all stored lines and counters. No output beat is issued in the cycle after reset is released.

Optional Feature:
- LINEBUF_OUT_READY_EN defined:
  - Adds input port data_out_ready (1 bit).
  - In S_READ, the read address advances only when data_out_ready=1 or the output register is empty.
  - data_out_* and the pulses hold stable while data_out_valid && !data_out_ready.
- Undefined: no port; reading proceeds unconditionally at one beat per cycle.

Decomposition:
- Package line_buffer_pkg holds:
  - state enum {S_FILL, S_READ, S_FLUSH}
  - NUM_LINE_BUFS=4 and its 2-bit index type
  - a zero-pixel constant
- One sub-module, line_ram:
  - COLS x WIDTH, single write port and single read port, registered read, no reset on the storage.
  - 4 instances are used, selected by wr_buf and rd_buf.

Test Plan (COLS=4, ROWS=4, WIDTH=8, pixel value = 16*row+col):
- Continuous input, no stalls:
  - The first beat appears after the 8th pixel is accepted, with (d2,d1,d0) = (0,0x00,0x10).
  - The 16 beats come out in row order.
  - Row 3 beats are (0x2c,0x3c,0) for col c.
  - frame_done pulses exactly once, on the 16th beat.
- Backpressure: hold the reader pace so fill_cnt reaches 4 -> pixel_in_ready=0 until the next line retires, with no pixel lost or duplicated.
- Input gaps: pixel_in_valid toggles every other cycle -> output identical to the continuous case; beats only start once the required lines are complete.
- Back-to-back frames -> the first beat of frame 2 row 0 shows d2=0, and no row from frame 1 leaks through.
- Reset low asserted during row 2 of a frame, then a new frame is sent -> data_out_valid=0 after reset, and the next frame's output is exact.
- LINEBUF_OUT_READY_EN with data_out_ready low for 3 cycles mid-line -> the output holds its value, and the column sequence resumes without a gap.
